// File: rtl/serial_adder_ctrl_amisha.sv
// serial_adder_ctrl_amisha
// Wide adder that reuses a single 4-bit carry adder slice. It processes one
// nibble per clock, least-significant nibble first, and keeps the carry in a
// register between passes. A start/busy/done handshake frames each operation.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, the sub_amisha port exists. With sub=1 the operation
//   computes A-B mod 2^W: each B nibble is inverted and the carry starts at 1.
//   In that mode cout_amisha=1 means "no borrow" (A >= B).

module serial_adder_ctrl_amisha #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk_amisha,
  input  logic                   rst_n_amisha,
  input  logic                   start_amisha,
  input  logic [4*NIBBLES-1:0]   a_amisha,
  input  logic [4*NIBBLES-1:0]   b_amisha,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                   sub_amisha,
`endif
  output logic                   busy_amisha,
  output logic                   done_amisha,
  output logic [4*NIBBLES-1:0]   sum_amisha,
  output logic                   cout_amisha
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = 4;  // index width; holds up to 8 passes with headroom

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t          r_state;
  logic [W-1:0]    r_a;        // operand A, shifted right one nibble per pass
  logic [W-1:0]    r_b;        // operand B, shifted right one nibble per pass
  logic [W-1:0]    r_acc;      // partial result, nibbles enter at the top
  logic            r_carry;    // carry between passes
  logic [KW-1:0]   r_k;        // index of the nibble being processed
  logic [W-1:0]    r_sum;
  logic            r_cout;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  state_t          w_state_next;
  logic            w_busy;
  logic            w_done;
  logic            w_accept;    // IDLE and start: operand capture edge
  logic            w_run;       // this edge processes a nibble
  logic            w_last;      // this edge processes the top nibble
  logic            w_sub;       // effective subtract mode for the current op
  logic            w_carry_init;
  logic [3:0]      w_an;        // A nibble into the slice
  logic [3:0]      w_bn;        // B nibble into the slice (inverted for sub)
  logic [3:0]      w_s;         // slice sum
  logic [4:0]      w_c;         // slice carry chain, w_c[0] is carry-in
  logic [W-1:0]    w_acc_next;

`ifdef SERIAL_ADD_SUB_EN
  logic            r_sub;

  // Subtract select is captured with the operands and held for the whole op.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= sub_amisha;
    end
  end

  assign w_sub        = r_sub;
  assign w_carry_init = sub_amisha;  // two's complement: ~B + 1
`else
  assign w_sub        = 1'b0;
  assign w_carry_init = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && start_amisha;
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_k == KW'(NIBBLES - 1));

  // ---------------------------------------------------------------------
  // 4-bit ripple-carry slice, the same shape as the stand-alone nibble adder
  // ---------------------------------------------------------------------
  assign w_an   = r_a[3:0];
  assign w_bn   = r_b[3:0] ^ {4{w_sub}};
  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign w_s[gi]   = w_an[gi] ^ w_bn[gi] ^ w_c[gi];
      assign w_c[gi+1] = (w_an[gi] & w_bn[gi]) | (w_c[gi] & (w_an[gi] ^ w_bn[gi]));
    end
  endgenerate

  // New nibble goes in at the top; after NIBBLES passes the least significant
  // nibble has migrated down to bits [3:0].
  assign w_acc_next = {w_s, r_acc[W-1:4]};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_amisha) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Operand shift registers, carry, index and partial result.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= a_amisha;
      r_b     <= b_amisha;
      r_acc   <= '0;
      r_carry <= w_carry_init;
      r_k     <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_acc   <= w_acc_next;
      r_carry <= w_c[4];
      r_k     <= r_k + KW'(1);
    end
  end

  // Result registers update only on the edge that finishes the last pass,
  // so the previous result stays visible while a new op is running.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_acc_next;
      r_cout <= w_c[4];
    end
  end

  assign busy_amisha = w_busy;
  assign done_amisha = w_done;
  assign sum_amisha  = r_sum;
  assign cout_amisha = r_cout;

endmodule
